mem_ctrl_mp: RTL

Parametrised multi-port memory controller between the pipeline's memory clients (instruction fetch, load/store buffer, and later additional ports) and the byte-wide single-port RAM. It grants one request at a time by round-robin and serialises each 1/2/4-byte access into byte cycles. It sign- or zero-extends loads, lets in-flight stores complete on pipeline flush, and restarts loads interrupted by `rdy` stalls.

---
 rtl/mem_ctrl_mp_pkg.sv | 28 ++
 rtl/mem_ctrl_mp_rr_arbiter.sv | 43 ++++
 rtl/mem_ctrl_mp.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_mp_pkg.sv
// rtl/mem_ctrl_mp_pkg.sv - size encodings, FSM state constants and size helper for mem_ctrl_mp
package mem_ctrl_mp_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_RLAST = 2'd2;
  localparam state_t ST_WRITE = 2'd3;

  // Byte count for a size code; code 3 and anything wider than the data path clamp to maxb.
  function automatic int size_bytes(input logic [1:0] size, input int maxb);
    int n;
    case (size)
      SZ_B:    n = 1;
      SZ_H:    n = 2;
      SZ_W:    n = 4;
      default: n = maxb;
    endcase
    if (n > maxb) n = maxb;
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_mp_rr_arbiter.sv
// rtl/mem_ctrl_mp_rr_arbiter.sv - round-robin one-hot arbiter with registered priority pointer
module mem_ctrl_mp_rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 enable,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        ptr
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          found;

  // First requester at or after the pointer wins; the pointer then moves just past it.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NUM_PORTS]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % NUM_PORTS);
      end
    end
    grant = '0;
    if (enable && found) grant[win] = 1'b1;
    ptr_d = ptr_q;
    if (advance) ptr_d = (int'(win) == NUM_PORTS - 1) ? '0 : win + PW'(1);
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_ctrl_mp.sv
// rtl/mem_ctrl_mp.sv - multi-port byte-serialising memory controller; optional MEM_CTRL_IO_STALL_EN adds io_buffer_full
module mem_ctrl_mp
  import mem_ctrl_mp_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rdy,
  input  logic                             flush,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [2*NUM_PORTS-1:0]           req_size,
  input  logic [NUM_PORTS-1:0]             req_signed,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  req_addr,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic [ADDR_WIDTH-1:0]            mem_a,
  output logic                             mem_wr,
  output logic [7:0]                       mem_dout,
`ifdef MEM_CTRL_IO_STALL_EN
  input  logic                             io_buffer_full,
`endif
  input  logic [7:0]                       mem_din
);

  localparam int MAXB = DATA_WIDTH / 8;
  localparam int IW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           issued_q, issued_d;
  logic                    signed_q, signed_d;
  logic [PW-1:0]           port_q, port_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]    resp_valid_q, resp_valid_d;
  logic                    restart_q, restart_d;

  logic [NUM_PORTS-1:0]    grant;
  logic [PW-1:0]           rr_ptr_unused;
  logic                    arb_en;
  logic                    io_hold;

  logic [PW-1:0]           sel_idx;
  logic                    sel_we;
  logic [1:0]              sel_size;
  logic                    sel_signed;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  logic [DATA_WIDTH-1:0]   ext_data;
  logic                    ext_sign;

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_hold = (base_q[17:16] == 2'b11) && io_buffer_full;
`else
  assign io_hold = 1'b0;
`endif

  // Grants only from IDLE, never while frozen, flushing or in reset.
  assign arb_en = rst_n && rdy && !flush && (state_q == ST_IDLE);

  mem_ctrl_mp_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .enable  (arb_en),
    .advance (|grant),
    .grant   (grant),
    .ptr     (rr_ptr_unused)
  );

  assign req_ready = grant;

  // Mux the granted port's request fields.
  always_comb begin
    sel_idx    = '0;
    sel_we     = 1'b0;
    sel_size   = '0;
    sel_signed = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_idx    = PW'(p);
        sel_we     = req_we[p];
        sel_size   = req_size[2*p +: 2];
        sel_signed = req_signed[p];
        sel_addr   = req_addr[ADDR_WIDTH*p +: ADDR_WIDTH];
        sel_wdata  = req_wdata[DATA_WIDTH*p +: DATA_WIDTH];
      end
    end
  end

  // FSM, byte capture and load extension; a stalled read is replayed from its base.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    last_d       = last_q;
    issued_d     = issued_q;
    signed_d     = signed_q;
    port_d       = port_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    restart_d    = restart_q;
    resp_valid_d = rdy ? '0 : resp_valid_q;
    ext_data     = data_q;
    ext_sign     = 1'b0;
    if (!rdy) begin
      if (state_q == ST_READ || state_q == ST_RLAST) restart_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            base_d    = sel_addr;
            wdata_d   = sel_wdata;
            signed_d  = sel_signed;
            port_d    = sel_idx;
            last_d    = IW'(size_bytes(sel_size, MAXB) - 1);
            issued_d  = '0;
            data_d    = '0;
            restart_d = 1'b0;
            state_d   = sel_we ? ST_WRITE : ST_READ;
          end
        end
        ST_READ, ST_RLAST: begin
          if (flush) begin
            restart_d = 1'b0;
            state_d   = ST_IDLE;
          end else if (restart_q) begin
            restart_d = 1'b0;
            issued_d  = '0;
            data_d    = '0;
            state_d   = ST_READ;
          end else if (state_q == ST_READ) begin
            for (int b = 0; b < MAXB; b++) begin
              if (issued_q != '0 && IW'(b) == issued_q - IW'(1)) data_d[8*b +: 8] = mem_din;
            end
            if (issued_q == last_q) state_d = ST_RLAST;
            else                    issued_d = issued_q + IW'(1);
          end else begin
            for (int b = 0; b < MAXB; b++) begin
              if (IW'(b) == last_q) ext_data[8*b +: 8] = mem_din;
            end
            ext_sign = signed_q & mem_din[7];
            for (int b = 0; b < MAXB; b++) begin
              if (IW'(b) > last_q) ext_data[8*b +: 8] = {8{ext_sign}};
            end
            rdata_d              = ext_data;
            resp_valid_d[port_q] = 1'b1;
            state_d              = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (!io_hold) begin
            if (issued_q == last_q) begin
              rdata_d              = '0;
              resp_valid_d[port_q] = 1'b1;
              state_d              = ST_IDLE;
            end else begin
              issued_d = issued_q + IW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      wdata_q      <= '0;
      last_q       <= '0;
      issued_q     <= '0;
      signed_q     <= 1'b0;
      port_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      resp_valid_q <= '0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
      issued_q     <= issued_d;
      signed_q     <= signed_d;
      port_q       <= port_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      restart_q    <= restart_d;
    end
  end

  // RAM side: address during READ/WRITE, data and strobe only while writing.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state_q == ST_READ || state_q == ST_WRITE) mem_a = base_q + ADDR_WIDTH'(issued_q);
    if (state_q == ST_WRITE) begin
      for (int b = 0; b < MAXB; b++) begin
        if (IW'(b) == issued_q) mem_dout = wdata_q[8*b +: 8];
      end
      mem_wr = rdy && !io_hold;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

endmodule
